oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine for the pGB: snoops CPU writes to the DMA register at 0xFF46 and copies LENGTH bytes from source page `{reg,8'h00}` into sprite attribute memory (OAM, 0xFE00–0xFE9F). It sits between the DZCPU/MMU bus and the OAM RAM, directly downstream of CPU memory writes. While it runs, it owns the source read port and tells the MMU arbiter to block CPU accesses outside HRAM (0xFF80–0xFFFE).

## Interface
Parameters:
- LENGTH, 160, bytes per transfer; OAM index runs 0..LENGTH-1.
- START_DELAY, 1, idle bus cycles between the register write and the first source read; must be at least 1.

Ports:
- iClock  in  1  system clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCpuWe  in  1  CPU write strobe, as presented to the MMU.
- iCpuAddr  in  16  CPU address.
- iCpuData  in  8  CPU write data.
- oDmaReg  out  8  last value written to 0xFF46; the MMU returns this on reads of 0xFF46.
- oBusy  out  1  transfer in progress; the MMU arbiter blocks non-HRAM CPU accesses.
- oMemRe  out  1  source read strobe.
- oMemAddr  out  16  source read address.
- iMemData  in  8  source data, valid exactly 1 cycle after oMemRe (synchronous RAM).
- oOamWe  out  1  OAM write strobe.
- oOamAddr  out  8  OAM index 0..LENGTH-1.
- oOamData  out  8  OAM write data.
- oDone  out  1  one-cycle pulse on the final OAM write.

## Operation
- Trigger: a cycle with iCpuWe=1 and iCpuAddr=16'hFF46 latches iCpuData into oDmaReg and starts a transfer. The trigger is evaluated in every state.
- Source page: src = oDmaReg if oDmaReg <= 8'hDF, otherwise oDmaReg - 8'h20 (echo/OAM/IO pages alias onto WRAM). oMemAddr = {src, rdIdx}.
- States:
  - IDLE: oBusy=0. On trigger, load delay counter with START_DELAY-1 and go to START.
  - START: oBusy=1, no reads. When the counter reaches 0, go to XFER with rdIdx=0.
  - XFER: assert oMemRe with rdIdx and increment rdIdx each cycle. When an OAM write is pending, assert oOamWe with oOamAddr=rdIdx-1 and oOamData=iMemData. After issuing the read for rdIdx=LENGTH-1, go to DRAIN.
  - DRAIN: oMemRe=0. Perform the final OAM write (index LENGTH-1) and pulse oDone, then go to IDLE.
- Retrigger while in START, XFER or DRAIN:
  - oDmaReg updates and the state goes to START with the counter reloaded.
  - The in-flight read is discarded: no OAM write, no oDone in the following cycle.
  - The transfer restarts at index 0.
- Writes to any address other than 0xFF46 are ignored.
- rdIdx is 8 bits and never wraps past LENGTH-1.

## Timing
- Reset values: oDmaReg=8'h00 (GB post-boot value 0xFF is written by software), oBusy=0, oMemRe=0, oMemAddr=16'h0000, oOamWe=0, oOamAddr=0, oOamData=0, oDone=0, state IDLE.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values. No further OAM writes occur.
- Trigger sampled at edge T, with START_DELAY=1:
  - oBusy=1 from T+1.
  - First read (index 0) at T+2.
  - OAM write of index k at T+3+k.
  - Last write (index LENGTH-1) together with oDone at T+2+LENGTH.
  - oBusy=0 at T+3+LENGTH.
- Total busy cycles = START_DELAY + LENGTH + 1 (162 with the defaults).
- oOamWe and oMemRe are both high in every XFER cycle after the first.
- oDone and oOamWe are never asserted while oBusy=0.

## Test plan
- Basic copy: fill 0xC000–0xC09F with the pattern i^8'h5A, then write 8'hC0 to 0xFF46. Required: 160 OAM writes with OAM[i]=i^8'h5A, oDone at T+162, oBusy high for exactly 162 cycles, oDmaReg=8'hC0.
- Aliasing: write 8'hFE to 0xFF46. Required: first oMemAddr=16'hDE00 and last oMemAddr=16'hDE9F.
- Retrigger: write 8'hC0, then write 8'hD0 at the 50th OAM write. Required: no write of index 50 from the 0xC0 page, oMemAddr restarts at 16'hD000, all 160 indices are written from 0xD0xx, and exactly one oDone.
- Reset mid-op: assert iReset during XFER at index 80. Required: next cycle oBusy=0, no oOamWe afterwards, oDmaReg=0.
- Non-trigger writes: write to 0xFF45 and 0xFF47 with iCpuWe=1, and present 0xFF46 with iCpuWe=0. Required: state stays IDLE and oDmaReg is unchanged.
- Back-to-back: start a second trigger the cycle after oDone. Required: the second transfer proceeds normally with correct START_DELAY spacing.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to 0xFF46 and copies LENGTH bytes from the
// selected source page into sprite attribute memory, owning the source read port.
module oam_dma #(
    parameter int unsigned LENGTH      = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oDmaReg,
    output logic        oBusy,
    output logic        oMemRe,
    output logic [15:0] oMemAddr,
    input  logic [7:0]  iMemData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic        oDone
);

    localparam logic [15:0]  DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]   LAST_IDX     = 8'(LENGTH - 1);
    localparam int unsigned  CNT_W        = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_DRAIN
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [7:0]         rd_idx_q,   rd_idx_d;
    logic [7:0]         dma_reg_q,  dma_reg_d;
    logic               busy_q,     busy_d;
    logic               mem_re_q,   mem_re_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               oam_we_q,   oam_we_d;
    logic [7:0]         oam_addr_q, oam_addr_d;
    logic               done_q,     done_d;

    logic               trigger;
    logic [7:0]         src_page;

    // Pages above WRAM (echo, OAM, IO) alias back down by 0x20.
    assign trigger  = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
    assign src_page = (dma_reg_q <= 8'hDF) ? dma_reg_q : (dma_reg_q - 8'h20);

    // Next state and next registered outputs; a trigger overrides every state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_idx_d   = rd_idx_q;
        dma_reg_d  = dma_reg_q;
        busy_d     = 1'b0;
        mem_re_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        oam_we_d   = 1'b0;
        oam_addr_d = oam_addr_q;
        done_d     = 1'b0;

        if (trigger) begin
            dma_reg_d = iCpuData;
            state_d   = S_START;
            cnt_d     = CNT_LOAD;
            rd_idx_d  = 8'h00;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_START: begin
                    busy_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d    = S_XFER;
                        rd_idx_d   = 8'h00;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {src_page, 8'h00};
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_XFER: begin
                    // The byte read this cycle lands in OAM next cycle.
                    busy_d     = 1'b1;
                    oam_we_d   = 1'b1;
                    oam_addr_d = rd_idx_q;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        done_d  = 1'b1;
                    end else begin
                        rd_idx_d   = rd_idx_q + 8'd1;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {src_page, rd_idx_q + 8'd1};
                    end
                end
                S_DRAIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_idx_q   <= 8'h00;
            dma_reg_q  <= 8'h00;
            busy_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            oam_we_q   <= 1'b0;
            oam_addr_q <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            dma_reg_q  <= dma_reg_d;
            busy_q     <= busy_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            oam_we_q   <= oam_we_d;
            oam_addr_q <= oam_addr_d;
            done_q     <= done_d;
        end
    end

    assign oDmaReg  = dma_reg_q;
    assign oBusy    = busy_q;
    assign oMemRe   = mem_re_q;
    assign oMemAddr = mem_addr_q;
    assign oOamWe   = oam_we_q;
    assign oOamAddr = oam_addr_q;
    assign oDone    = done_q;
    // Source RAM data arrives in the write cycle itself, so it passes straight through.
    assign oOamData = oam_we_q ? iMemData : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: synchronous source RAM model, per-scenario tasks
// with inline checks against hand-derived cycle timelines.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [7:0]  dma_reg;
    logic        busy;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:159];
    bit          written [0:159];

    int n_cmp = 0;
    int n_bad = 0;

    oam_dma dut (
        .iClock  (clk),
        .iReset  (rst),
        .iCpuWe  (cpu_we),
        .iCpuAddr(cpu_addr),
        .iCpuData(cpu_data),
        .oDmaReg (dma_reg),
        .oBusy   (busy),
        .oMemRe  (mem_re),
        .oMemAddr(mem_addr),
        .iMemData(mem_data),
        .oOamWe  (oam_we),
        .oOamAddr(oam_addr),
        .oOamData(oam_data),
        .oDone   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic we);
        cpu_we = we; cpu_addr = a; cpu_data = d;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
    endtask

    // {busy, re, we, done} for cycle c after the trigger edge (LENGTH=160, START_DELAY=1)
    function automatic logic [3:0] exp_ctl(input int c);
        exp_ctl[3] = (c >= 1) && (c <= 162);
        exp_ctl[2] = (c >= 2) && (c <= 161);
        exp_ctl[1] = (c >= 3) && (c <= 162);
        exp_ctl[0] = (c == 162);
    endfunction

    task automatic test_reset();
        rst = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
        tick(); tick();
        n_cmp++; if (dma_reg !== 8'h00) begin n_bad++; $display("FAIL reset_dmareg got %h want 00", dma_reg); end
        n_cmp++; if ({busy, mem_re, oam_we, done} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctl got %b want 0000", {busy, mem_re, oam_we, done}); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_memaddr got %h want 0000", mem_addr); end
        n_cmp++; if ({oam_addr, oam_data} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_oam got %h want 0000", {oam_addr, oam_data}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int done_at = -1;
        logic [3:0] e;
        for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        cpu_write(16'hFF46, 8'hC0, 1'b1);
        for (int c = 1; c <= 170; c++) begin
            e = exp_ctl(c);
            if (busy) busy_cnt++;
            if (done) done_at = c;
            n_cmp++; if ({busy, mem_re, oam_we, done} !== e) begin
                n_bad++; $display("FAIL basic_ctl c=%0d got %b want %b", c, {busy, mem_re, oam_we, done}, e); end
            if (e[2]) begin
                n_cmp++; if (mem_addr !== 16'hC000 + 16'(c - 2)) begin
                    n_bad++; $display("FAIL basic_addr c=%0d got %h want %h", c, mem_addr, 16'hC000 + 16'(c - 2)); end
            end
            if (e[1]) begin
                n_cmp++; if ({oam_addr, oam_data} !== {8'(c - 3), 8'(c - 3) ^ 8'h5A}) begin
                    n_bad++; $display("FAIL basic_oam c=%0d got %h want %h", c, {oam_addr, oam_data},
                                      {8'(c - 3), 8'(c - 3) ^ 8'h5A}); end
            end
            tick();
        end
        n_cmp++; if (busy_cnt != 162) begin n_bad++; $display("FAIL basic_busy_len got %0d want 162", busy_cnt); end
        n_cmp++; if (done_at != 162) begin n_bad++; $display("FAIL basic_done_at got %0d want 162", done_at); end
        n_cmp++; if (dma_reg !== 8'hC0) begin n_bad++; $display("FAIL basic_dmareg got %h want c0", dma_reg); end
    endtask

    task automatic test_nontrigger();
        cpu_write(16'hFF45, 8'h11, 1'b1);
        n_cmp++; if ({busy, dma_reg} !== {1'b0, 8'hC0}) begin
            n_bad++; $display("FAIL nontrig_ff45 got %h want 0c0", {busy, dma_reg}); end
        cpu_write(16'hFF47, 8'h22, 1'b1);
        n_cmp++; if ({busy, dma_reg} !== {1'b0, 8'hC0}) begin
            n_bad++; $display("FAIL nontrig_ff47 got %h want 0c0", {busy, dma_reg}); end
        cpu_write(16'hFF46, 8'h33, 1'b0);
        n_cmp++; if ({busy, dma_reg} !== {1'b0, 8'hC0}) begin
            n_bad++; $display("FAIL nontrig_nowe got %h want 0c0", {busy, dma_reg}); end
        tick(); tick();
        n_cmp++; if ({busy, mem_re, oam_we} !== 3'b000) begin
            n_bad++; $display("FAIL nontrig_idle got %b want 000", {busy, mem_re, oam_we}); end
    endtask

    task automatic test_alias();
        logic [15:0] first = 16'hFFFF;
        logic [15:0] last = 16'hFFFF;
        int nreads = 0;
        cpu_write(16'hFF46, 8'hFE, 1'b1);
        for (int c = 1; c <= 200; c++) begin
            if (mem_re) begin
                if (nreads == 0) first = mem_addr;
                last = mem_addr;
                nreads++;
            end
            tick();
        end
        n_cmp++; if (first !== 16'hDE00) begin n_bad++; $display("FAIL alias_first got %h want de00", first); end
        n_cmp++; if (last !== 16'hDE9F) begin n_bad++; $display("FAIL alias_last got %h want de9f", last); end
        n_cmp++; if (nreads != 160) begin n_bad++; $display("FAIL alias_reads got %0d want 160", nreads); end
        n_cmp++; if (dma_reg !== 8'hFE) begin n_bad++; $display("FAIL alias_dmareg got %h want fe", dma_reg); end
    endtask

    task automatic test_retrigger();
        int ndone = 0;
        int nwr = 0;
        int nbad_data = 0;
        int nmissing = 0;
        bit found = 0;
        logic [15:0] first = 16'hFFFF;
        for (int i = 0; i < 160; i++) mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
        cpu_write(16'hFF46, 8'hC0, 1'b1);
        for (int c = 1; c <= 200 && !found; c++) begin
            if (done) ndone++;
            if (oam_we && oam_addr == 8'd49) found = 1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL retrig_reach49 got 0 want 1"); end
        cpu_write(16'hFF46, 8'hD0, 1'b1);
        n_cmp++; if ({busy, oam_we, done} !== 3'b100) begin
            n_bad++; $display("FAIL retrig_discard got %b want 100", {busy, oam_we, done}); end
        for (int i = 0; i < 160; i++) written[i] = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done) ndone++;
            if (mem_re && first == 16'hFFFF) first = mem_addr;
            if (oam_we) begin
                nwr++;
                if (oam_addr < 8'd160) written[oam_addr] = 1;
                if (oam_data !== (oam_addr ^ 8'hA5)) nbad_data++;
            end
            tick();
        end
        for (int i = 0; i < 160; i++) if (!written[i]) nmissing++;
        n_cmp++; if (first !== 16'hD000) begin n_bad++; $display("FAIL retrig_first got %h want d000", first); end
        n_cmp++; if (nwr != 160) begin n_bad++; $display("FAIL retrig_writes got %0d want 160", nwr); end
        n_cmp++; if (nmissing != 0) begin n_bad++; $display("FAIL retrig_missing got %0d want 0", nmissing); end
        n_cmp++; if (nbad_data != 0) begin n_bad++; $display("FAIL retrig_data got %0d bad want 0", nbad_data); end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL retrig_done got %0d want 1", ndone); end
    endtask

    task automatic test_back_to_back();
        bit found = 0;
        int busy_cnt = 0;
        int done_at = -1;
        logic [3:0] e;
        cpu_write(16'hFF46, 8'hC0, 1'b1);
        for (int c = 1; c <= 200 && !found; c++) begin
            if (done) found = 1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL b2b_first_done got 0 want 1"); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_gap got %b want 00", {busy, done}); end
        cpu_write(16'hFF46, 8'hD0, 1'b1);
        for (int c = 1; c <= 166; c++) begin
            e = exp_ctl(c);
            if (busy) busy_cnt++;
            if (done) done_at = c;
            n_cmp++; if ({busy, mem_re, oam_we, done} !== e) begin
                n_bad++; $display("FAIL b2b_ctl c=%0d got %b want %b", c, {busy, mem_re, oam_we, done}, e); end
            if (e[2]) begin
                n_cmp++; if (mem_addr !== 16'hD000 + 16'(c - 2)) begin
                    n_bad++; $display("FAIL b2b_addr c=%0d got %h want %h", c, mem_addr, 16'hD000 + 16'(c - 2)); end
            end
            if (e[1]) begin
                n_cmp++; if ({oam_addr, oam_data} !== {8'(c - 3), 8'(c - 3) ^ 8'hA5}) begin
                    n_bad++; $display("FAIL b2b_oam c=%0d got %h want %h", c, {oam_addr, oam_data},
                                      {8'(c - 3), 8'(c - 3) ^ 8'hA5}); end
            end
            tick();
        end
        n_cmp++; if (busy_cnt != 162) begin n_bad++; $display("FAIL b2b_busy_len got %0d want 162", busy_cnt); end
        n_cmp++; if (done_at != 162) begin n_bad++; $display("FAIL b2b_done_at got %0d want 162", done_at); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int late = 0;
        cpu_write(16'hFF46, 8'hC0, 1'b1);
        for (int c = 1; c <= 200 && !found; c++) begin
            if (mem_re && mem_addr[7:0] == 8'd80) found = 1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach80 got 0 want 1"); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({busy, mem_re, oam_we, done} !== 4'b0000) begin
            n_bad++; $display("FAIL rstmid_ctl got %b want 0000", {busy, mem_re, oam_we, done}); end
        n_cmp++; if (dma_reg !== 8'h00) begin n_bad++; $display("FAIL rstmid_dmareg got %h want 00", dma_reg); end
        for (int c = 0; c < 20; c++) begin
            if (oam_we || busy || done) late++;
            tick();
        end
        n_cmp++; if (late != 0) begin n_bad++; $display("FAIL rstmid_after got %0d active cycles want 0", late); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nontrigger();
        test_alias();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
